// File: rtl/zion_rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ write-back units.
// Optional per-requester stall counters when ZION_RF_WB_ARB_PERF_EN is defined.
module zion_rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned RV64    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_vld,
  input  logic [5*NUM_REQ-1:0]              req_rd,
  input  logic [32*(1+RV64)*NUM_REQ-1:0]    req_dat,
  output logic [NUM_REQ-1:0]                req_rdy,
  output logic                              wr_vld,
  output logic [4:0]                        wr_rd,
  output logic [32*(1+RV64)-1:0]            wr_dat,
  output logic [$clog2(NUM_REQ)-1:0]        wr_src,
  input  logic                              wr_rdy,
  output logic [31:0]                       pend_mask
`ifdef ZION_RF_WB_ARB_PERF_EN
  ,
  input  logic                              perf_clr,
  output logic [16*NUM_REQ-1:0]             stall_cnt
`endif
);

  localparam int unsigned XLEN = 32 * (1 + RV64);
  localparam int unsigned SW   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] x0_req;
  logic [NUM_REQ-1:0] grant_oh;
  logic               hi_vld, lo_vld, grant_vld;
  logic [SW-1:0]      hi_idx, lo_idx, grant_idx;
  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_dat;
  logic               free;

  logic               wr_vld_q, wr_vld_d;
  logic [4:0]         wr_rd_q, wr_rd_d;
  logic [XLEN-1:0]    wr_dat_q, wr_dat_d;
  logic [SW-1:0]      wr_src_q, wr_src_d;
  logic [SW-1:0]      ptr_q, ptr_d;

  // x0 writes are acknowledged immediately and kept out of arbitration
  always_comb begin
    elig   = '0;
    x0_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]   = req_vld[i] && (req_rd[5*i +: 5] != 5'd0);
      x0_req[i] = req_vld[i] && (req_rd[5*i +: 5] == 5'd0);
    end
  end

  // lowest eligible index at/above ptr wins, else lowest eligible overall (wrap)
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_vld = 1'b1;
        lo_idx = SW'(i);
        if (SW'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = SW'(i);
        end
      end
    end
    grant_vld = hi_vld || lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_rd  = '0;
    sel_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SW'(i)) begin
        sel_rd  = req_rd[5*i +: 5];
        sel_dat = req_dat[XLEN*i +: XLEN];
      end
    end
  end

  assign free     = !wr_vld_q || wr_rdy;
  assign grant_oh = NUM_REQ'(1) << grant_idx;
  assign req_rdy  = x0_req | ((grant_vld && free) ? grant_oh : '0);

  // output stage: load on grant when free, drain to idle when free with no grant
  always_comb begin
    wr_vld_d = wr_vld_q;
    wr_rd_d  = wr_rd_q;
    wr_dat_d = wr_dat_q;
    wr_src_d = wr_src_q;
    ptr_d    = ptr_q;
    if (free) begin
      wr_vld_d = grant_vld;
      if (grant_vld) begin
        wr_rd_d  = sel_rd;
        wr_dat_d = sel_dat;
        wr_src_d = grant_idx;
        ptr_d    = (grant_idx == SW'(NUM_REQ - 1)) ? '0 : grant_idx + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      wr_rd_q  <= '0;
      wr_dat_q <= '0;
      wr_src_q <= '0;
      ptr_q    <= '0;
    end else begin
      wr_vld_q <= wr_vld_d;
      wr_rd_q  <= wr_rd_d;
      wr_dat_q <= wr_dat_d;
      wr_src_q <= wr_src_d;
      ptr_q    <= ptr_d;
    end
  end

  assign wr_vld    = wr_vld_q;
  assign wr_rd     = wr_rd_q;
  assign wr_dat    = wr_dat_q;
  assign wr_src    = wr_src_q;
  assign pend_mask = wr_vld_q ? (32'd1 << wr_rd_q) : 32'd0;

`ifdef ZION_RF_WB_ARB_PERF_EN
  logic [15:0] stall_q [NUM_REQ];
  logic [15:0] stall_d [NUM_REQ];

  // saturating count of cycles a requester waits without acceptance
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stall_d[i] = stall_q[i];
      if (perf_clr) begin
        stall_d[i] = 16'd0;
      end else if (req_vld[i] && !req_rdy[i] && (stall_q[i] != 16'hFFFF)) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stall_q[i] <= stall_d[i];
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stall_cnt[16*i +: 16] = stall_q[i];
  end
`endif

endmodule

// File: tb/tb_zion_rf_wb_arbiter.sv
// Directed bench for zion_rf_wb_arbiter (NUM_REQ=3, 32-bit datapath).
module tb_zion_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_vld;
  logic [14:0] req_rd;
  logic [95:0] req_dat;
  logic [2:0]  req_rdy;
  logic        wr_vld;
  logic [4:0]  wr_rd;
  logic [31:0] wr_dat;
  logic [1:0]  wr_src;
  logic        wr_rdy;
  logic [31:0] pend_mask;
`ifdef ZION_RF_WB_ARB_PERF_EN
  logic        perf_clr;
  logic [47:0] stall_cnt;
`endif

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  zion_rf_wb_arbiter #(.NUM_REQ(3), .RV64(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rd    (req_rd),
    .req_dat   (req_dat),
    .req_rdy   (req_rdy),
    .wr_vld    (wr_vld),
    .wr_rd     (wr_rd),
    .wr_dat    (wr_dat),
    .wr_src    (wr_src),
    .wr_rdy    (wr_rdy),
    .pend_mask (pend_mask)
`ifdef ZION_RF_WB_ARB_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [4:0] rd,
                           input logic [31:0] dat, input logic [1:0] src);
    check({tag, "_vld"}, 64'(wr_vld), 64'(vld));
    check({tag, "_rd"},  64'(wr_rd),  64'(rd));
    check({tag, "_dat"}, 64'(wr_dat), 64'(dat));
    check({tag, "_src"}, 64'(wr_src), 64'(src));
    check({tag, "_pend"}, 64'(pend_mask), vld ? (64'd1 << rd) : 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    req_vld = '0;
    req_rd  = '0;
    req_dat = '0;
    wr_rdy  = 1'b1;
`ifdef ZION_RF_WB_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    tick();
    tick();
    check_out("reset", 1'b0, 5'd0, 32'd0, 2'd0);
    rst = 1'b0;

    // round-robin with all three requesters continuously valid
    req_rd  = {5'd3, 5'd2, 5'd1};
    req_dat = {32'h33, 32'h22, 32'h11};
    req_vld = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      int unsigned s;
      s = k % 3;
      check("rr_rdy", 64'(req_rdy), 64'd1 << s);
      tick();
      check_out("rr", 1'b1, 5'(s + 1), 32'h11 * (s + 1), 2'(s));
    end
    req_vld = '0;
    tick();
    check_out("idle", 1'b0, 5'd3, 32'h33, 2'd2);

    // back-pressure: requester 1 writes rd=5 then the port is stalled 3 cycles
    req_rd[9:5]    = 5'd5;
    req_dat[63:32] = 32'hDEADBEEF;
    req_vld        = 3'b010;
    #1;
    check("bp_load_rdy", 64'(req_rdy), 64'b010);
    tick();
    check_out("bp_load", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    wr_rdy  = 1'b0;
    req_rd  = {5'd6, 5'd0, 5'd4};
    req_dat = {32'h66, 32'h0, 32'h44};
    req_vld = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_rdy", 64'(req_rdy), 64'b010);
      tick();
      check_out("bp_hold", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    end
    wr_rdy = 1'b1;
    #1;
    check("bp_release_rdy", 64'(req_rdy), 64'b110);
    tick();
    check_out("wrap_g2", 1'b1, 5'd6, 32'h66, 2'd2);
    req_vld = 3'b001;
    #1;
    check("wrap_g0_rdy", 64'(req_rdy), 64'b001);
    tick();
    check_out("wrap_g0", 1'b1, 5'd4, 32'h44, 2'd0);
    req_rd  = {5'd3, 5'd2, 5'd1};
    req_vld = 3'b111;
    #1;
    check("ptr_one_rdy", 64'(req_rdy), 64'b010);
    req_vld = '0;
    tick();
    check_out("drain", 1'b0, 5'd4, 32'h44, 2'd0);

    // x0 absorption alongside a real write, then an x0-only stream
    req_rd          = {5'd7, 5'd2, 5'd0};
    req_dat[95:64]  = 32'h77;
    req_vld         = 3'b101;
    #1;
    check("x0_rdy", 64'(req_rdy), 64'b101);
    tick();
    check_out("x0_wr7", 1'b1, 5'd7, 32'h77, 2'd2);
    req_vld = 3'b001;
    #1;
    check("x0_only_rdy", 64'(req_rdy), 64'b001);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("x0_only", 1'b0, 5'd7, 32'h77, 2'd2);
    end

    // asynchronous reset while a stalled write is held
    req_rd[9:5]    = 5'd9;
    req_dat[63:32] = 32'h99;
    req_vld        = 3'b010;
    tick();
    check_out("pre_rst", 1'b1, 5'd9, 32'h99, 2'd1);
    req_vld = '0;
    wr_rdy  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 5'd0, 32'd0, 2'd0);
    #1;
    rst     = 1'b0;
    wr_rdy  = 1'b1;
    req_rd  = {5'd3, 5'd2, 5'd1};
    req_dat = {32'h33, 32'h22, 32'h11};
    req_vld = 3'b111;
    #1;
    check("post_rst_rdy", 64'(req_rdy), 64'b001);
    tick();
    check_out("post_rst", 1'b1, 5'd1, 32'h11, 2'd0);

`ifdef ZION_RF_WB_ARB_PERF_EN
    // stall counters: clear, count 5 blocked cycles, clear, saturate
    req_vld  = 3'b001;
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    wr_rdy   = 1'b0;
    req_vld  = 3'b010;
    repeat (5) tick();
    check("stall_r1", 64'(stall_cnt[31:16]), 64'd5);
    check("stall_r0", 64'(stall_cnt[15:0]), 64'd0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("stall_clr", 64'(stall_cnt[31:16]), 64'd0);
    repeat (70000) tick();
    check("stall_sat", 64'(stall_cnt[31:16]), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/zion_rf_wb_arbiter.md
Name: zion_rf_wb_arbiter

Overview:
- Shares the single register-file write port (vld/rd/dat write channel) among NUM_REQ write-back requesters, for example ALU, LSU and MUL/DIV.
- Round-robin arbitration feeds one registered output stage with a valid/ready handshake toward the register file.
- Writes to x0 are absorbed without consuming a write slot.
- Sits between execution-unit write-back and the integer register file.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- RV64, 0, 0 gives a 32-bit datapath; 1 gives a 64-bit datapath. XLEN = 32*(1+RV64).

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  NUM_REQ  per-requester write request.
- req_rd  input  5*NUM_REQ  destination register; requester i occupies bits [5i+4:5i].
- req_dat  input  XLEN*NUM_REQ  write data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
- req_rdy  output  NUM_REQ  request accepted this cycle.
- wr_vld  output  1  register-file write valid.
- wr_rd  output  5  register-file write address.
- wr_dat  output  XLEN  register-file write data.
- wr_src  output  $clog2(NUM_REQ)  index of the requester whose write is held.
- wr_rdy  input  1  register file accepts the write; tie to 1 if the port is never stolen.
- pend_mask  output  32  one-hot of wr_rd when wr_vld=1, else 0.

Behaviour:
- Reset (asynchronous, rst=1): wr_vld=0, wr_rd=0, wr_dat=0, wr_src=0, round-robin pointer ptr=0.
  - Reset mid-operation discards any held write; the requester is not re-signalled.
- Eligibility: requester i is eligible when req_vld[i]=1 and its rd!=0.
- x0 requests (req_vld[i]=1, rd=0):
  - req_rdy[i]=1 combinationally in the same cycle, regardless of output-stage state.
  - Never enter arbitration, never update ptr, never produce wr_vld.
- Stage free: free = !wr_vld || wr_rdy.
- Grant: the first eligible requester scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ. One grant at most per cycle.
- Handshake:
  - req_rdy[g]=free for the granted requester g; 0 for other eligible requesters.
  - Requesters hold req_vld, req_rd and req_dat stable until req_rdy=1.
- On a cycle with free=1 and a grant g, the next edge sets:
  - wr_vld=1, wr_rd=req_rd[g], wr_dat=req_dat[g], wr_src=g.
  - ptr = (g+1) mod NUM_REQ, with wrap-around at NUM_REQ-1 going to 0.
- On a cycle with free=1 and no grant: next edge sets wr_vld=0. wr_rd, wr_dat and wr_src hold their last values. ptr holds.
- On a cycle with wr_vld=1 and wr_rdy=0: the output stage holds all values. All req_rdy for eligible requesters are 0; x0 requests are still accepted.
- Throughput and latency:
  - One write per cycle with wr_rdy held at 1; no bubble on back-to-back grants.
  - Latency from acceptance to wr_vld is 1 cycle.
- pend_mask is derived combinationally from the output register and is used by issue logic for hazard checks.
- Two requesters targeting the same rd in one cycle: serialized in round-robin order. No merging.
- Non-eligible requesters are ignored when ptr points at them; the scan simply passes over them.

Optional Feature:
- Macro: ZION_RF_WB_ARB_PERF_EN.
- When defined, adds output port stall_cnt (16*NUM_REQ bits): one 16-bit counter per requester.
  - Counter increments each cycle with req_vld[i]=1 and req_rdy[i]=0.
  - Saturates at 16'hFFFF.
  - Resets to 0 on rst.
  - Also cleared synchronously by an added input port perf_clr (1 bit).
- When not defined, neither port exists and no counter logic is generated.

Test Plan:
- Reset: assert rst mid-transfer with wr_vld=1 -> wr_vld=0, wr_rd=0, wr_dat=0, wr_src=0 immediately; after release, first grant goes to requester 0.
- All three requesters valid continuously (rd=1,2,3, wr_rdy=1) -> wr_src sequence 0,1,2,0,1,2, one write per cycle; pend_mask cycles 0x2, 0x4, 0x8.
- Back-pressure: requester 1 writes rd=5, dat=0xDEADBEEF, then wr_rdy=0 for 3 cycles -> outputs stable for those 3 cycles; req_rdy=0 for eligible requesters; transfer completes on the first cycle with wr_rdy=1.
- x0 absorption: requester 0 rd=0 with requester 2 rd=7 in the same cycle -> req_rdy=3'b101 in that cycle; next cycle wr_vld=1, wr_rd=7, wr_src=2; a stream of only rd=0 never raises wr_vld.
- Pointer wrap: ptr=2 with requesters 0 and 2 valid -> requester 2 granted first, then requester 0; ptr becomes 0, then 1.
- With ZION_RF_WB_ARB_PERF_EN: requester 1 blocked for 5 cycles -> stall_cnt[31:16]=5; pulsing perf_clr -> 0; forcing 70000 blocked cycles -> counter reads 0xFFFF.
